// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the ID/EX operand stage:
// ALU control codes and forwarding select values.
package id_ex_operand_stage_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Per-operand forwarding comparator and priority mux.
// Ports: held addr/data, EX/MEM and MEM/WB triples -> select, value.
module fwd_select
  import id_ex_operand_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              exmem_we_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_data_i,
  input  logic              memwb_we_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_data_i,
  output logic [1:0]        sel_o,
  output logic [DATA_W-1:0] data_o
);

  logic ex_hit;
  logic wb_hit;

  // x0 is hardwired, so it is never a forwarding target.
  assign ex_hit = exmem_we_i && (exmem_rd_i != '0)
               && (exmem_rd_i == addr_i);
  assign wb_hit = memwb_we_i && (memwb_rd_i != '0)
               && (memwb_rd_i == addr_i) && !ex_hit;

  always_comb begin
    sel_o  = FWD_REG;
    data_o = data_i;
    unique case (1'b1)
      ex_hit: begin
        sel_o  = FWD_EXMEM;
        data_o = exmem_data_i;
      end
      wb_hit: begin
        sel_o  = FWD_MEMWB;
        data_o = memwb_data_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX register with operand forwarding, stall hold and flush bubble.
// Ports: ID fields in, EX/MEM + MEM/WB results in, ALU operands out.
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [CTRL_W-1:0] alu_ctrl_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              exmem_reg_write_i,
  input  logic [REG_AW-1:0] exmem_rd_i,
  input  logic [DATA_W-1:0] exmem_result_i,
  input  logic              memwb_reg_write_i,
  input  logic [REG_AW-1:0] memwb_rd_i,
  input  logic [DATA_W-1:0] memwb_result_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] src1_o,
  output logic [DATA_W-1:0] src2_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_write_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);

  logic              valid_q;
  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [DATA_W-1:0] rs_data_q;
  logic [DATA_W-1:0] rt_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              alu_src_q;
  logic              reg_write_q;

  logic [DATA_W-1:0] fwd_a_data;
  logic [DATA_W-1:0] fwd_b_data;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush_i) begin
      valid_q     <= 1'b0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (stall_i) begin
      // Refresh held operands so results retiring
      // during the stall are not lost.
      rs_data_q <= fwd_a_data;
      rt_data_q <= fwd_b_data;
    end else begin
      valid_q     <= valid_i;
      rs_q        <= rs_addr_i;
      rt_q        <= rt_addr_i;
      rd_q        <= rd_addr_i;
      rs_data_q   <= rs_data_i;
      rt_data_q   <= rt_data_i;
      imm_q       <= imm_i;
      ctrl_q      <= alu_ctrl_i;
      alu_src_q   <= alu_src_i;
      reg_write_q <= reg_write_i;
    end
  end

  fwd_select #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_a (
    .addr_i      (rs_q),
    .data_i      (rs_data_q),
    .exmem_we_i  (exmem_reg_write_i),
    .exmem_rd_i  (exmem_rd_i),
    .exmem_data_i(exmem_result_i),
    .memwb_we_i  (memwb_reg_write_i),
    .memwb_rd_i  (memwb_rd_i),
    .memwb_data_i(memwb_result_i),
    .sel_o       (fwd_a_o),
    .data_o      (fwd_a_data)
  );

  fwd_select #(
    .DATA_W(DATA_W),
    .REG_AW(REG_AW)
  ) u_fwd_b (
    .addr_i      (rt_q),
    .data_i      (rt_data_q),
    .exmem_we_i  (exmem_reg_write_i),
    .exmem_rd_i  (exmem_rd_i),
    .exmem_data_i(exmem_result_i),
    .memwb_we_i  (memwb_reg_write_i),
    .memwb_rd_i  (memwb_rd_i),
    .memwb_data_i(memwb_result_i),
    .sel_o       (fwd_b_o),
    .data_o      (fwd_b_data)
  );

  assign valid_o      = valid_q;
  assign src1_o       = fwd_a_data;
  assign store_data_o = fwd_b_data;
  assign src2_o       = alu_src_q ? imm_q : fwd_b_data;
  assign ctrl_o       = ctrl_q;
  assign rd_addr_o    = rd_q;
  assign reg_write_o  = reg_write_q & valid_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Bench for id_ex_operand_stage: directed cases plus
// randomized traffic against a behavioural model.
module tb_id_ex_operand_stage;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i, flush_i, valid_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [3:0]  alu_ctrl_i;
  logic        alu_src_i, reg_write_i;
  logic        exmem_reg_write_i;
  logic [4:0]  exmem_rd_i;
  logic [31:0] exmem_result_i;
  logic        memwb_reg_write_i;
  logic [4:0]  memwb_rd_i;
  logic [31:0] memwb_result_i;
  logic        valid_o;
  logic [31:0] src1_o, src2_o, store_data_o;
  logic [3:0]  ctrl_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o;
  logic [1:0]  fwd_a_o, fwd_b_o;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .imm_i(imm_i), .alu_ctrl_i(alu_ctrl_i),
    .alu_src_i(alu_src_i), .reg_write_i(reg_write_i),
    .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_rd_i(exmem_rd_i),
    .exmem_result_i(exmem_result_i),
    .memwb_reg_write_i(memwb_reg_write_i),
    .memwb_rd_i(memwb_rd_i),
    .memwb_result_i(memwb_result_i),
    .valid_o(valid_o), .src1_o(src1_o), .src2_o(src2_o),
    .store_data_o(store_data_o), .ctrl_o(ctrl_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rs_data, rt_data, imm;
    logic [3:0]  ctrl;
    logic        alu_src, reg_write;
  } entry_t;

  entry_t m = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  // Which pipeline result a given register should read now.
  function automatic logic [1:0] src_of(logic [4:0] r);
    if (r == 0) return 2'd0;
    if (exmem_reg_write_i && exmem_rd_i == r) return 2'd2;
    if (memwb_reg_write_i && memwb_rd_i == r) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [31:0] value_of(logic [4:0] r,
                                           logic [31:0] d);
    case (src_of(r))
      2'd2: return exmem_result_i;
      2'd1: return memwb_result_i;
      default: return d;
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else if (flush_i) m <= '0;
    else if (stall_i) begin
      m.rs_data <= value_of(m.rs, m.rs_data);
      m.rt_data <= value_of(m.rt, m.rt_data);
    end else begin
      m <= '{valid: valid_i, rs: rs_addr_i, rt: rt_addr_i,
             rd: rd_addr_i, rs_data: rs_data_i,
             rt_data: rt_data_i, imm: imm_i,
             ctrl: alu_ctrl_i, alu_src: alu_src_i,
             reg_write: reg_write_i};
    end
  end

  always @(negedge clk_i) begin
    if (rst_n) begin
      chk("m_valid", 32'(valid_o), 32'(m.valid));
      chk("m_src1", src1_o, value_of(m.rs, m.rs_data));
      chk("m_store", store_data_o, value_of(m.rt, m.rt_data));
      chk("m_src2", src2_o, m.alu_src ? m.imm
                            : value_of(m.rt, m.rt_data));
      chk("m_ctrl", 32'(ctrl_o), 32'(m.ctrl));
      chk("m_rd", 32'(rd_addr_o), 32'(m.rd));
      chk("m_we", 32'(reg_write_o),
          32'(m.reg_write && m.valid));
      chk("m_fwd_a", 32'(fwd_a_o), 32'(src_of(m.rs)));
      chk("m_fwd_b", 32'(fwd_b_o), 32'(src_of(m.rt)));
    end
  end

  task automatic slot();
    @(negedge clk_i);
    #2;
  endtask

  task automatic idle();
    stall_i = 0; flush_i = 0; valid_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0;
    rs_data_i = 0; rt_data_i = 0; imm_i = 0;
    alu_ctrl_i = 0; alu_src_i = 0; reg_write_i = 0;
    exmem_reg_write_i = 0; exmem_rd_i = 0;
    exmem_result_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0;
    memwb_result_i = 0;
  endtask

  task automatic load(logic [4:0] rs, logic [4:0] rt,
                      logic [31:0] a, logic [31:0] b);
    idle();
    valid_i = 1; reg_write_i = 1; rd_addr_i = 5'd9;
    rs_addr_i = rs; rt_addr_i = rt;
    rs_data_i = a; rt_data_i = b;
    alu_ctrl_i = 4'b0010;
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_we", 32'(reg_write_o), 0);
    chk("rst_src1", src1_o, 0);
    slot();
    rst_n = 1;

    // plain capture
    load(5'd1, 5'd2, 32'd5, 32'd7);
    slot();
    #1;
    chk("cap_src1", src1_o, 32'd5);
    chk("cap_src2", src2_o, 32'd7);
    chk("cap_ctrl", 32'(ctrl_o), 32'h2);
    chk("cap_fwd_a", 32'(fwd_a_o), 0);
    chk("cap_fwd_b", 32'(fwd_b_o), 0);
    chk("cap_we", 32'(reg_write_o), 1);

    // double match, then MEM/WB only
    load(5'd3, 5'd2, 32'h33, 32'h44);
    slot();
    idle();
    exmem_reg_write_i = 1; exmem_rd_i = 3;
    exmem_result_i = 32'h11;
    memwb_reg_write_i = 1; memwb_rd_i = 3;
    memwb_result_i = 32'h22;
    #1;
    chk("dbl_src1", src1_o, 32'h11);
    chk("dbl_fwd_a", 32'(fwd_a_o), 32'h2);
    exmem_reg_write_i = 0;
    #1;
    chk("wb_src1", src1_o, 32'h22);
    chk("wb_fwd_a", 32'(fwd_a_o), 32'h1);

    // x0 never forwarded; immediate selected
    slot();
    load(5'd0, 5'd0, 32'h55, 32'h66);
    alu_src_i = 1; imm_i = 32'hFFFF_FFFC;
    slot();
    idle();
    exmem_reg_write_i = 1; exmem_rd_i = 0;
    exmem_result_i = 32'hFF;
    #1;
    chk("x0_src1", src1_o, 32'h55);
    chk("x0_fwd_a", 32'(fwd_a_o), 0);
    chk("imm_src2", src2_o, 32'hFFFF_FFFC);

    // stall retention
    slot();
    load(5'd1, 5'd4, 32'h1, 32'h1);
    slot();
    idle();
    stall_i = 1; rt_addr_i = 5'd6; rt_data_i = 32'hDEAD;
    memwb_reg_write_i = 1; memwb_rd_i = 4;
    memwb_result_i = 32'd9;
    #1;
    chk("stl1_store", store_data_o, 32'd9);
    slot();
    memwb_reg_write_i = 0;
    #1;
    chk("stl2_store", store_data_o, 32'd9);
    chk("stl2_rd", 32'(rd_addr_o), 32'd9);

    // stall with flush
    slot();
    stall_i = 1; flush_i = 1;
    slot();
    #1;
    chk("sf_valid", 32'(valid_o), 0);
    chk("sf_we", 32'(reg_write_o), 0);

    // asynchronous reset mid-operation
    load(5'd2, 5'd3, 32'h77, 32'h88);
    slot();
    idle();
    #1;
    rst_n = 0;
    #1;
    chk("arst_valid", 32'(valid_o), 0);
    chk("arst_we", 32'(reg_write_o), 0);
    chk("arst_ctrl", 32'(ctrl_o), 0);
    chk("arst_src1", src1_o, 0);
    slot();
    rst_n = 1;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      slot();
      stall_i = ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 9) == 0);
      valid_i = $urandom_range(0, 1);
      rs_addr_i = 5'($urandom_range(0, 7));
      rt_addr_i = 5'($urandom_range(0, 7));
      rd_addr_i = 5'($urandom);
      rs_data_i = $urandom;
      rt_data_i = $urandom;
      imm_i = $urandom;
      alu_ctrl_i = 4'($urandom);
      alu_src_i = $urandom_range(0, 1);
      reg_write_i = $urandom_range(0, 1);
      exmem_reg_write_i = $urandom_range(0, 1);
      exmem_rd_i = 5'($urandom_range(0, 7));
      exmem_result_i = $urandom;
      memwb_reg_write_i = $urandom_range(0, 1);
      memwb_rd_i = 5'($urandom_range(0, 7));
      memwb_result_i = $urandom;
    end
    slot();
    idle();
    slot();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
